// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, shift, rotate, load, clear and invert, chosen per cycle by mode.
// The only state is q. All other outputs are decoded combinationally from q.
module univ_shift_reg #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             zero
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_INV  = 3'b111;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] shr_v;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] ror_v;
    logic [WIDTH-1:0] q_next;

    // A one-bit register has no interior slice: shifts take the serial input, rotates hold.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shl_v = sin_r;
            assign shr_v = sin_l;
            assign rol_v = q_r;
            assign ror_v = q_r;
        end else begin : g_wn
            assign shl_v = {q_r[WIDTH-2:0], sin_r};
            assign shr_v = {sin_l, q_r[WIDTH-1:1]};
            assign rol_v = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            assign ror_v = {q_r[0], q_r[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        q_next = q_r;
        case (mode)
            MODE_HOLD: q_next = q_r;
            MODE_SHL:  q_next = shl_v;
            MODE_SHR:  q_next = shr_v;
            MODE_ROL:  q_next = rol_v;
            MODE_ROR:  q_next = ror_v;
            MODE_LOAD: q_next = pdata;
            MODE_CLR:  q_next = '0;
            MODE_INV:  q_next = ~q_r;
            default:   q_next = q_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= RST_VAL;
        end else if (en) begin
            q_r <= q_next;
        end
    end

    assign q        = q_r;
    assign qbar     = ~q_r;
    assign sout_msb = q_r[WIDTH-1];
    assign sout_lsb = q_r[0];
    assign zero     = (q_r == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: an 8-bit instance with RST_VAL=A5 and a 1-bit instance.
// Expected values are hand-computed constants.
module tb_univ_shift_reg;

    logic clk;
    int   checks;
    int   errors;

    // 8-bit instance
    logic       a_rst, a_en, a_sin_r, a_sin_l;
    logic [2:0] a_mode;
    logic [7:0] a_pdata, a_q, a_qbar;
    logic       a_msb, a_lsb, a_zero;

    // 1-bit instance
    logic       b_rst, b_en, b_sin_r, b_sin_l;
    logic [2:0] b_mode;
    logic [0:0] b_pdata, b_q, b_qbar;
    logic       b_msb, b_lsb, b_zero;

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
        .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode),
        .sin_r(a_sin_r), .sin_l(a_sin_l), .pdata(a_pdata),
        .q(a_q), .qbar(a_qbar), .sout_msb(a_msb), .sout_lsb(a_lsb), .zero(a_zero)
    );

    univ_shift_reg #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
        .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode),
        .sin_r(b_sin_r), .sin_l(b_sin_l), .pdata(b_pdata),
        .q(b_q), .qbar(b_qbar), .sout_msb(b_msb), .sout_lsb(b_lsb), .zero(b_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, return 1 time unit later for sampling.
    task automatic step8(input logic r, input logic e, input logic [2:0] m,
                         input logic sr, input logic sl, input logic [7:0] pd);
        a_rst = r; a_en = e; a_mode = m; a_sin_r = sr; a_sin_l = sl; a_pdata = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic r, input logic e, input logic [2:0] m,
                         input logic sr, input logic sl, input logic pd);
        b_rst = r; b_en = e; b_mode = m; b_sin_r = sr; b_sin_l = sl; b_pdata = pd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] shl_bits;
        logic       lsb0;
        checks = 0;
        errors = 0;
        a_rst = 1'b0; a_en = 1'b0; a_mode = 3'b000; a_sin_r = 1'b0; a_sin_l = 1'b0; a_pdata = 8'h00;
        b_rst = 1'b0; b_en = 1'b0; b_mode = 3'b000; b_sin_r = 1'b0; b_sin_l = 1'b0; b_pdata = 1'b0;
        @(posedge clk);
        #1;

        // Reset overrides a pending load
        step8(1'b1, 1'b1, 3'b101, 1'b0, 1'b0, 8'hFF);
        check("rst_q", a_q, 8'hA5);
        check("rst_qbar", a_qbar, 8'h5A);
        check("rst_zero", {7'b0, a_zero}, 8'h00);
        check("rst_msb", {7'b0, a_msb}, 8'h01);
        check("rst_lsb", {7'b0, a_lsb}, 8'h01);
        step8(1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 8'hFF);
        check("rst_hold_en0", a_q, 8'hA5);

        // Load, invert, clear
        step8(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 8'h3C);
        check("load_3c", a_q, 8'h3C);
        step8(1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 8'hFF);
        check("hold_en1", a_q, 8'h3C);
        step8(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 8'h00);
        check("inv_q", a_q, 8'hC3);
        check("inv_qbar", a_qbar, 8'h3C);
        step8(1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 8'h00);
        check("clr_q", a_q, 8'h00);
        check("clr_zero", {7'b0, a_zero}, 8'h01);

        // Serial shift-left, first bit first: 1,0,1,1,0,0,1,0
        shl_bits = 8'b10110010;
        for (int i = 7; i >= 0; i--) begin
            step8(1'b0, 1'b1, 3'b001, shl_bits[i], 1'b0, 8'h00);
        end
        check("shl_q", a_q, 8'hB2);
        check("shl_msb", {7'b0, a_msb}, 8'h01);
        check("shl_lsb", {7'b0, a_lsb}, 8'h00);

        // Shift-right and rotates from 81
        step8(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 8'h81);
        step8(1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 8'h00);
        check("shr_sl0", a_q, 8'h40);
        step8(1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 8'h00);
        check("shr_sl1", a_q, 8'hA0);
        step8(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 8'h81);
        step8(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 8'h00);
        check("rol", a_q, 8'h03);
        step8(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 8'h81);
        step8(1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 8'h00);
        check("ror", a_q, 8'hC0);
        step8(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 8'h81);
        for (int i = 0; i < 8; i++) begin
            step8(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 8'h00);
        end
        check("rol_x8", a_q, 8'h81);

        // Enable low freezes q across every mode; sout_lsb sampled at both clock phases
        step8(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 8'h5A);
        lsb0 = 1'b0;
        for (int m = 0; m < 8; m++) begin
            step8(1'b0, 1'b0, 3'(m), 1'b1, 1'b1, 8'hFF);
            check("en0_q", a_q, 8'h5A);
            @(negedge clk);
            lsb0 = lsb0 | a_lsb;
        end
        check("en0_lsb", {7'b0, lsb0}, 8'h00);

        // Reset in the middle of a right-shift stream
        step8(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 8'h0F);
        step8(1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 8'h00);
        check("stream_shr", a_q, 8'h07);
        step8(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 8'h00);
        check("stream_rst", a_q, 8'hA5);
        step8(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 8'h12);
        check("stream_load", a_q, 8'h12);

        // One-bit instance
        step1(1'b1, 1'b1, 3'b111, 1'b1, 1'b1, 1'b1);
        check("w1_rst", {7'b0, b_q}, 8'h00);
        check("w1_rst_zero", {7'b0, b_zero}, 8'h01);
        step1(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
        check("w1_shl", {7'b0, b_q}, 8'h01);
        check("w1_qbar", {7'b0, b_qbar}, 8'h00);
        step1(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        check("w1_inv0", {7'b0, b_q}, 8'h00);
        step1(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        check("w1_inv1", {7'b0, b_q}, 8'h01);
        step1(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
        check("w1_rol", {7'b0, b_q}, 8'h01);
        step1(1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
        check("w1_ror", {7'b0, b_q}, 8'h01);
        check("w1_msb", {7'b0, b_msb}, 8'h01);
        check("w1_lsb", {7'b0, b_lsb}, 8'h01);
        step1(1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1);
        check("w1_shr", {7'b0, b_q}, 8'h00);
        step1(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 1'b1);
        check("w1_load", {7'b0, b_q}, 8'h01);
        step1(1'b0, 1'b1, 3'b110, 1'b1, 1'b1, 1'b1);
        check("w1_clr", {7'b0, b_q}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
